iob_ram_2p_banked: RTL and testbench



---
 rtl/iob_ram_2p_banked_if.sv | 26 ++
 rtl/iob_ram_2p_banked.sv | 113 +++++++++++
 tb/tb_iob_ram_2p_banked.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/iob_ram_2p_banked_if.sv
// ext_mem_* port set between the iob_ram_2p_asym wrapper (master) and the
// banked two-port RAM (slave).
interface iob_ram_2p_banked_if #(
  parameter int DATA_W = 8,
  parameter int N      = 4,
  parameter int ADDR_W = 4
);
  logic [N-1:0]        ext_mem_w_en;
  logic [ADDR_W-1:0]   ext_mem_w_addr;
  logic [N*DATA_W-1:0] ext_mem_w_data;
  logic                ext_mem_r_en;
  logic [ADDR_W-1:0]   ext_mem_r_addr;
  logic [N*DATA_W-1:0] ext_mem_r_data;

  modport master (
    output ext_mem_w_en, ext_mem_w_addr, ext_mem_w_data,
    output ext_mem_r_en, ext_mem_r_addr,
    input  ext_mem_r_data
  );

  modport slave (
    input  ext_mem_w_en, ext_mem_w_addr, ext_mem_w_data,
    input  ext_mem_r_en, ext_mem_r_addr,
    output ext_mem_r_data
  );
endinterface

// File: rtl/iob_ram_2p_banked.sv
// N-bank two-port RAM (shared write/read address, per-bank write enables, read-first).
// Define IOB_RAM_2P_BANKED_CLEAR_EN to add the post-reset clear sequencer writing INIT_VAL.
module iob_ram_2p_banked #(
  parameter int                DATA_W   = 8,
  parameter int                N        = 4,
  parameter int                ADDR_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  iob_ram_2p_banked_if.slave   ext_mem,
  output logic                 init_busy
);
  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [0:0]        ST_CLEAR  = 1'b0;
  localparam logic [0:0]        ST_READY  = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

  logic [0:0]          state_r;
  logic [ADDR_W-1:0]   cnt_r;
  logic                init_busy_r;
  logic [N-1:0]        wr_en_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [N*DATA_W-1:0] wr_data_s;
  logic                rd_en_s;
  logic [N*DATA_W-1:0] rd_word_s;
  logic [N*DATA_W-1:0] r_data_r;

`ifdef IOB_RAM_2P_BANKED_CLEAR_EN
  // Clear sequencer: visit every word once after reset, then release user traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_CLEAR;
      cnt_r       <= '0;
      init_busy_r <= 1'b1;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          cnt_r <= cnt_r + ADDR_W'(1);
          if (cnt_r == LAST_ADDR) begin
            state_r     <= ST_READY;
            init_busy_r <= 1'b0;
          end else begin
            state_r     <= ST_CLEAR;
            init_busy_r <= 1'b1;
          end
        end
        ST_READY: begin
          state_r     <= ST_READY;
          cnt_r       <= cnt_r;
          init_busy_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_CLEAR;
          cnt_r       <= '0;
          init_busy_r <= 1'b1;
        end
      endcase
    end
  end
`else
  assign state_r     = ST_READY;
  assign cnt_r       = '0;
  assign init_busy_r = 1'b0;
`endif

  // Single write port shared by the clear sequencer and the user; rst drops everything.
  always_comb begin
    wr_en_s   = '0;
    wr_addr_s = ext_mem.ext_mem_w_addr;
    wr_data_s = ext_mem.ext_mem_w_data;
    rd_en_s   = 1'b0;
    if (rst) begin
      wr_en_s = '0;
      rd_en_s = 1'b0;
    end else if (state_r == ST_CLEAR) begin
      wr_en_s   = '1;
      wr_addr_s = cnt_r;
      wr_data_s = {N{INIT_VAL}};
      rd_en_s   = 1'b0;
    end else begin
      wr_en_s = ext_mem.ext_mem_w_en;
      rd_en_s = ext_mem.ext_mem_r_en;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_bank
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Bank storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
      if (wr_en_s[k]) begin
        mem_r[wr_addr_s] <= wr_data_s[k*DATA_W +: DATA_W];
      end
    end

    assign rd_word_s[k*DATA_W +: DATA_W] = mem_r[ext_mem.ext_mem_r_addr];
  end

  // Output register samples the pre-write contents, giving read-first collisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_r <= '0;
    end else if (rd_en_s) begin
      r_data_r <= rd_word_s;
    end else begin
      r_data_r <= r_data_r;
    end
  end

  assign ext_mem.ext_mem_r_data = r_data_r;
  assign init_busy              = init_busy_r;
endmodule

// File: tb/tb_iob_ram_2p_banked.sv
// Scoreboard bench for iob_ram_2p_banked; expectations follow IOB_RAM_2P_BANKED_CLEAR_EN.
`timescale 1ns/1ps
module tb_iob_ram_2p_banked;
  localparam int          DATA_W    = 8;
  localparam int          N         = 4;
  localparam int          ADDR_W    = 4;
  localparam logic [7:0]  INIT_VAL  = 8'hA5;
  localparam logic [31:0] INIT_WORD = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_busy;

  iob_ram_2p_banked_if #(.DATA_W(DATA_W), .N(N), .ADDR_W(ADDR_W)) m ();

  iob_ram_2p_banked #(
    .DATA_W(DATA_W), .N(N), .ADDR_W(ADDR_W), .INIT_VAL(INIT_VAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ext_mem(m),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          errors   = 0;
  logic [31:0] exp_q[$];
  logic        rd_pend  = 1'b0;
  logic        rst_pend = 1'b0;
  logic        hold_chk = 1'b0;
  logic [31:0] last_exp = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Remember what the DUT saw at each edge so the monitor knows what to expect.
  always @(posedge clk) begin
    rd_pend  <= m.ext_mem_r_en & ~rst;
    rst_pend <= rst;
  end

  // Monitor: compare r_data after reset, after each read, and while held.
  always @(negedge clk) begin
    if (rst_pend) begin
      last_exp = 32'h0;
      chk("reset_rdata", m.ext_mem_r_data, 32'h0);
    end else if (rd_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %h expected no read", m.ext_mem_r_data);
      end else begin
        last_exp = exp_q.pop_front();
        chk("read_data", m.ext_mem_r_data, last_exp);
      end
    end else if (hold_chk) begin
      chk("hold_rdata", m.ext_mem_r_data, last_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m.ext_mem_w_en   = 4'h0;
    m.ext_mem_w_addr = 4'h0;
    m.ext_mem_w_data = 32'h0;
    m.ext_mem_r_en   = 1'b0;
    m.ext_mem_r_addr = 4'h0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] en);
    m.ext_mem_w_en   = en;
    m.ext_mem_w_addr = addr;
    m.ext_mem_w_data = data;
    tick();
    m.ext_mem_w_en   = 4'h0;
  endtask

  task automatic rd(input logic [3:0] addr, input logic [31:0] exp);
    m.ext_mem_r_en   = 1'b1;
    m.ext_mem_r_addr = addr;
    exp_q.push_back(exp);
    tick();
    m.ext_mem_r_en   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Walk the 16 clear cycles; optionally poke a write and a read that must be ignored.
  task automatic clear_phase(input bit poke);
    for (int i = 1; i <= 16; i++) begin
      if (poke && i == 3) begin
        m.ext_mem_w_en   = 4'hF;
        m.ext_mem_w_addr = 4'd2;
        m.ext_mem_w_data = 32'hFFFFFFFF;
      end
      if (poke && i == 5) begin
        m.ext_mem_r_en   = 1'b1;
        m.ext_mem_r_addr = 4'd2;
        exp_q.push_back(32'h0);
      end
      tick();
      idle_inputs();
      chk("init_busy_clear", {31'b0, init_busy}, (i < 16) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic common_rw();
    for (int i = 0; i < 16; i++) wr(4'(i), 32'h10 + 32'(i), 4'hF);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'h10 + 32'(i));
    wr(4'd3, 32'h11223344, 4'hF);
    wr(4'd3, 32'hAABBCCDD, 4'b0101);
    rd(4'd3, 32'h11BB33DD);
    wr(4'd5, 32'h00000005, 4'hF);
    m.ext_mem_w_en   = 4'hF;
    m.ext_mem_w_addr = 4'd5;
    m.ext_mem_w_data = 32'hDEADBEEF;
    rd(4'd5, 32'h00000005);
    m.ext_mem_w_en   = 4'h0;
    rd(4'd5, 32'hDEADBEEF);
    tick();
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
`ifdef IOB_RAM_2P_BANKED_CLEAR_EN
    chk("init_busy_reset", {31'b0, init_busy}, 32'd1);
    rst = 1'b0;
    hold_chk = 1'b1;
    clear_phase(1'b1);
    for (int i = 0; i < 16; i++) rd(4'(i), INIT_WORD);
    common_rw();
    wr(4'd7, 32'h77777777, 4'hF);
    rd(4'd7, 32'h77777777);
    tick();
    pulse_reset();
    chk("init_busy_rerun", {31'b0, init_busy}, 32'd1);
    clear_phase(1'b0);
    rd(4'd2, INIT_WORD);
    rd(4'd7, INIT_WORD);
`else
    chk("init_busy_reset", {31'b0, init_busy}, 32'd0);
    rst = 1'b0;
    hold_chk = 1'b1;
    wr(4'd9, 32'h99887766, 4'hF);
    chk("init_busy_run", {31'b0, init_busy}, 32'd0);
    rd(4'd9, 32'h99887766);
    common_rw();
    chk("init_busy_run2", {31'b0, init_busy}, 32'd0);
    pulse_reset();
    chk("init_busy_after_rst", {31'b0, init_busy}, 32'd0);
    wr(4'd9, 32'h01020304, 4'hF);
    rd(4'd9, 32'h01020304);
`endif
    tick();
    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
